// File: rtl/msx_pkg.sv
// Shared types and constants for the MSX SDRAM-side blocks.
// Used by the slot bridge and the request timer.
package msx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } bridge_state_t;

    // Open-bus value, shared with the slot mux default
    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/sdram_req_timer.sv
// Saturating watchdog for one SDRAM controller transaction.
// expired stays high once the count reaches TIMEOUT.
module sdram_req_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/sdram_slot_bridge.sv
// Slot-side front end to the shared SDRAM controller: one-entry read
// cache, write pass-through with back-pressure, and a transaction watchdog.
module sdram_slot_bridge
    import msx_pkg::*;
#(
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] slot_addr,
    input  logic [7:0]        slot_din,
    input  logic              slot_rd,
    input  logic              slot_we,
    output logic [7:0]        slot_dout,
    output logic              slot_ready,
    output logic              wr_busy,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [7:0]        ctl_din,
    output logic              ctl_rd,
    output logic              ctl_we,
    input  logic              ctl_ack,
    input  logic [7:0]        ctl_dout,
    output logic              timeout_err
);

    bridge_state_t     state;
    logic              we_d;
    logic              cache_valid;
    logic [ADDR_W-1:0] cache_tag;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_din;

    logic we_edge;
    logic hit;
    logic tmr_load;
    logic tmr_en;
    logic expired;

    assign we_edge    = slot_we & ~we_d;
    assign hit        = cache_valid & (cache_tag == slot_addr);
    assign slot_ready = hit & ~wr_busy;
    assign tmr_load   = (state == RD_REQ) | (state == WR_REQ);
    assign tmr_en     = (state == RD_WAIT) | (state == WR_WAIT);

    sdram_req_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .enable (tmr_en),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            we_d        <= 1'b0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            slot_dout   <= FILL_BYTE;
            pend        <= 1'b0;
            pend_addr   <= '0;
            pend_din    <= '0;
            wr_busy     <= 1'b0;
            ctl_addr    <= '0;
            ctl_din     <= '0;
            ctl_rd      <= 1'b0;
            ctl_we      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            we_d   <= slot_we;
            ctl_rd <= 1'b0;
            ctl_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pend) begin
                        state    <= WR_REQ;
                        ctl_we   <= 1'b1;
                        ctl_addr <= pend_addr;
                        ctl_din  <= pend_din;
                        pend     <= 1'b0;
                    end else if (we_edge) begin
                        state    <= WR_REQ;
                        wr_busy  <= 1'b1;
                        ctl_we   <= 1'b1;
                        ctl_addr <= slot_addr;
                        ctl_din  <= slot_din;
                    end else if (slot_rd && !hit) begin
                        state       <= RD_REQ;
                        cache_tag   <= slot_addr;
                        cache_valid <= 1'b0;
                        ctl_rd      <= 1'b1;
                        ctl_addr    <= slot_addr;
                    end
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    // An issued read is never abandoned, even if slot_rd drops
                    if (ctl_ack) begin
                        state       <= IDLE;
                        slot_dout   <= ctl_dout;
                        cache_valid <= 1'b1;
                    end else if (expired) begin
                        state       <= IDLE;
                        slot_dout   <= FILL_BYTE;
                        cache_valid <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                WR_REQ: state <= WR_WAIT;
                WR_WAIT: begin
                    if (ctl_ack || expired) begin
                        state   <= IDLE;
                        wr_busy <= pend;
                        if (!ctl_ack) begin
                            timeout_err <= 1'b1;
                        end
                        if (ctl_addr == cache_tag) begin
                            cache_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Edge seen mid-transaction: hold it for the next IDLE cycle
            if (we_edge && state != IDLE && !pend) begin
                pend      <= 1'b1;
                pend_addr <= slot_addr;
                pend_din  <= slot_din;
                wr_busy   <= 1'b1;
            end
        end
    end

endmodule
